fifo_rptr_empty: RTL and testbench

Read-side pointer and status stage of the asynchronous FIFO, in the read clock domain directly downstream of the write-to-read pointer synchronizer. It consumes the two-flop-synchronized Gray write pointer and maintains the binary and Gray read pointers. It drives the read address into the dual-port memory and generates registered `empty`, `almost_empty`, occupancy level and underflow indications. The Gray read pointer it produces is what the read-to-write synchronizer carries back to the write side.

---
 rtl/fifo_rptr_empty_if.sv | 27 ++
 rtl/fifo_rptr_empty.sv | 70 +++++++
 tb/tb_fifo_rptr_empty.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_rptr_empty_if.sv
// Read-side bundle of the async FIFO: consumer request, synchronized write
// pointer in, read address / Gray read pointer / status flags out.
interface fifo_rptr_empty_if #(
  parameter int DEPTH = 8
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic              r_en;
  logic [PTR_W-1:0]  rsync_ptr2;
  logic [ADDR_W-1:0] raddr;
  logic [PTR_W-1:0]  rptr;
  logic              empty;
  logic              almost_empty;
  logic [PTR_W-1:0]  r_level;
  logic              underflow;

  modport master (
    output r_en, rsync_ptr2,
    input  raddr, rptr, empty, almost_empty, r_level, underflow
  );

  modport slave (
    input  r_en, rsync_ptr2,
    output raddr, rptr, empty, almost_empty, r_level, underflow
  );
endinterface

// File: rtl/fifo_rptr_empty.sv
// Async FIFO read-pointer stage: binary/Gray read pointers, registered empty,
// almost-empty, occupancy level and underflow pulse in the r_clk domain.
module fifo_rptr_empty #(
  parameter int DEPTH     = 8,
  parameter int AE_THRESH = 1
) (
  input logic              r_clk,
  input logic              rst,
  fifo_rptr_empty_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AE_LIMIT = PTR_W'(AE_THRESH);

  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rptr_q;
  logic [PTR_W-1:0] level_q;
  logic             empty_q;
  logic             ae_q;
  logic             underflow_q;

  logic             rinc;
  logic [PTR_W-1:0] rbin_next;
  logic [PTR_W-1:0] rgray_next;
  logic [PTR_W-1:0] wbin_s;
  logic [PTR_W-1:0] level_next;

  // NOTE: every variable gets a full default at the top of always_comb so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rinc       = bus.r_en & ~empty_q;
    rbin_next  = rbin + PTR_W'(rinc);
    rgray_next = (rbin_next >> 1) ^ rbin_next;

    // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
    wbin_s = bus.rsync_ptr2;
    for (int i = PTR_W - 2; i >= 0; i--) begin
      wbin_s[i] = wbin_s[i+1] ^ bus.rsync_ptr2[i];
    end

    level_next = wbin_s - rbin_next;
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge r_clk) begin
    if (rst) begin
      rbin        <= '0;
      rptr_q      <= '0;
      empty_q     <= 1'b1;
      ae_q        <= 1'b1;
      level_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      rbin        <= rbin_next;
      rptr_q      <= rgray_next;
      empty_q     <= (rgray_next == bus.rsync_ptr2);
      ae_q        <= (level_next <= AE_LIMIT);
      level_q     <= level_next;
      underflow_q <= bus.r_en & empty_q;
    end
  end

  assign bus.raddr        = rbin[ADDR_W-1:0];
  assign bus.rptr         = rptr_q;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = ae_q;
  assign bus.r_level      = level_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Bench for fifo_rptr_empty (DEPTH=8, AE_THRESH=1): directed scenarios plus a
// randomized run, all checked against a read/write-count model.
module tb_fifo_rptr_empty;
  logic r_clk;
  logic rst;

  fifo_rptr_empty_if #(.DEPTH(8)) bus ();

  fifo_rptr_empty #(.DEPTH(8), .AE_THRESH(1)) dut (
    .r_clk (r_clk),
    .rst   (rst),
    .bus   (bus)
  );

  initial begin
    r_clk = 1'b0;
    forever #5 r_clk = ~r_clk;
  end

  int total = 0;
  int bad   = 0;

  // Model: counts of entries written (as seen after sync) and read, unbounded.
  int   m_wr;
  int   m_rd;
  int   m_level;
  logic m_empty;
  logic m_ae;
  logic m_uf;

  function automatic logic [3:0] gray4(input int v);
    logic [3:0] b;
    b = 4'(v % 16);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] exp_rptr();
    return gray4(m_rd);
  endfunction

  function automatic logic [2:0] exp_raddr();
    return 3'(m_rd % 8);
  endfunction

  // Apply one cycle of inputs, advance the model, sample 1 ns after the edge.
  task automatic tick(input logic rst_v, input logic en, input int wr);
    rst            = rst_v;
    bus.r_en       = en;
    m_wr           = wr;
    bus.rsync_ptr2 = gray4(wr);
    if (rst_v) begin
      m_rd    = 0;
      m_level = 0;
      m_empty = 1'b1;
      m_ae    = 1'b1;
      m_uf    = 1'b0;
    end else begin
      m_uf = en && m_empty;
      if (en && !m_empty) m_rd = m_rd + 1;
      m_level = ((m_wr - m_rd) % 16 + 16) % 16;
      m_empty = (m_level == 0);
      m_ae    = (m_level <= 1);
    end
    @(posedge r_clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 0);
    tick(1'b1, 1'b1, 5);
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b need 1", bus.empty); end
    total++; if (bus.almost_empty !== 1'b1) begin bad++; $display("FAIL reset_ae: got %b need 1", bus.almost_empty); end
    total++; if (bus.rptr !== 4'b0000) begin bad++; $display("FAIL reset_rptr: got %b need 0000", bus.rptr); end
    total++; if (bus.r_level !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d need 0", bus.r_level); end
    total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL reset_underflow: got %b need 0", bus.underflow); end
    total++; if (bus.raddr !== 3'd0) begin bad++; $display("FAIL reset_raddr: got %0d need 0", bus.raddr); end
  endtask

  task automatic test_first_data();
    tick(1'b0, 1'b0, 0);
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL release_empty: got %b need 1", bus.empty); end
    tick(1'b0, 1'b0, 3);
    total++; if (bus.empty !== 1'b0) begin bad++; $display("FAIL first_empty: got %b need 0", bus.empty); end
    total++; if (bus.r_level !== 4'd3) begin bad++; $display("FAIL first_level: got %0d need 3", bus.r_level); end
    total++; if (bus.almost_empty !== 1'b0) begin bad++; $display("FAIL first_ae: got %b need 0", bus.almost_empty); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.raddr !== 3'(i)) begin bad++; $display("FAIL drain_raddr%0d: got %0d need %0d", i, bus.raddr, i); end
      tick(1'b0, 1'b1, 3);
      total++; if (bus.almost_empty !== m_ae) begin bad++; $display("FAIL drain_ae%0d: got %b need %b", i, bus.almost_empty, m_ae); end
    end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL drain_empty: got %b need 1", bus.empty); end
    total++; if (bus.rptr !== 4'b0010) begin bad++; $display("FAIL drain_rptr: got %b need 0010", bus.rptr); end
    total++; if (bus.r_level !== 4'd0) begin bad++; $display("FAIL drain_level: got %0d need 0", bus.r_level); end
    total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL drain_underflow: got %b need 0", bus.underflow); end
  endtask

  task automatic test_full_wrap();
    logic [3:0] prev;
    tick(1'b1, 1'b0, 0);
    for (int lap = 1; lap <= 2; lap++) begin
      tick(1'b0, 1'b0, 8 * lap);
      total++; if (bus.r_level !== 4'd8) begin bad++; $display("FAIL full_level%0d: got %0d need 8", lap, bus.r_level); end
      total++; if (bus.empty !== 1'b0) begin bad++; $display("FAIL full_empty%0d: got %b need 0", lap, bus.empty); end
      for (int i = 0; i < 8; i++) begin
        prev = bus.rptr;
        tick(1'b0, 1'b1, 8 * lap);
        total++; if ($countones(prev ^ bus.rptr) != 1) begin bad++; $display("FAIL gray_step: %b -> %b changes %0d bits need 1", prev, bus.rptr, $countones(prev ^ bus.rptr)); end
        total++; if (bus.empty !== m_empty) begin bad++; $display("FAIL wrap_empty: got %b need %b", bus.empty, m_empty); end
      end
      total++; if (bus.rptr !== ((lap == 1) ? 4'b1100 : 4'b0000)) begin bad++; $display("FAIL wrap_rptr%0d: got %b", lap, bus.rptr); end
      total++; if (bus.raddr !== 3'd0) begin bad++; $display("FAIL wrap_raddr%0d: got %0d need 0", lap, bus.raddr); end
    end
  endtask

  task automatic test_underflow();
    tick(1'b0, 1'b1, 16);
    total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL uf_pulse: got %b need 1", bus.underflow); end
    total++; if (bus.rptr !== 4'b0000) begin bad++; $display("FAIL uf_rptr: got %b need 0000", bus.rptr); end
    total++; if (bus.raddr !== 3'd0) begin bad++; $display("FAIL uf_raddr: got %0d need 0", bus.raddr); end
    tick(1'b0, 1'b0, 16);
    total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL uf_clear: got %b need 0", bus.underflow); end
  endtask

  task automatic test_simultaneous();
    tick(1'b0, 1'b0, 17);
    total++; if (bus.r_level !== 4'd1) begin bad++; $display("FAIL sim_setup: got %0d need 1", bus.r_level); end
    tick(1'b0, 1'b1, 18);
    total++; if (bus.empty !== 1'b0) begin bad++; $display("FAIL sim_empty: got %b need 0", bus.empty); end
    total++; if (bus.r_level !== 4'd1) begin bad++; $display("FAIL sim_level: got %0d need 1", bus.r_level); end
    total++; if (bus.raddr !== 3'd1) begin bad++; $display("FAIL sim_raddr: got %0d need 1", bus.raddr); end
  endtask

  task automatic test_reset_mid();
    tick(1'b0, 1'b0, 24);
    tick(1'b0, 1'b1, 24);
    tick(1'b0, 1'b1, 24);
    tick(1'b0, 1'b0, 24);
    total++; if (bus.raddr !== 3'd3 || bus.r_level !== 4'd5) begin bad++; $display("FAIL mid_setup: raddr %0d level %0d need 3 5", bus.raddr, bus.r_level); end
    tick(1'b1, 1'b1, 24);
    total++; if (bus.rptr !== 4'd0 || bus.raddr !== 3'd0) begin bad++; $display("FAIL mid_ptr: rptr %b raddr %0d need 0 0", bus.rptr, bus.raddr); end
    total++; if (bus.empty !== 1'b1 || bus.r_level !== 4'd0) begin bad++; $display("FAIL mid_status: empty %b level %0d need 1 0", bus.empty, bus.r_level); end
    total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL mid_underflow: got %b need 0", bus.underflow); end
    tick(1'b0, 1'b0, 5);
    total++; if (bus.empty !== 1'b0 || bus.r_level !== 4'd5) begin bad++; $display("FAIL mid_release: empty %b level %0d need 0 5", bus.empty, bus.r_level); end
  endtask

  task automatic test_random();
    logic [3:0] prev;
    int         rd_before;
    int         wr;
    logic       en;
    logic       r;
    for (int n = 0; n < 600; n++) begin
      prev      = bus.rptr;
      rd_before = m_rd;
      r         = ($urandom_range(0, 49) == 0);
      en        = 1'($urandom_range(0, 1));
      wr        = m_wr;
      if (r) wr = m_rd + int'($urandom_range(0, 8));
      else if ($urandom_range(0, 2) != 0) wr = m_wr + int'($urandom_range(0, 8 - (m_wr - m_rd)));
      if (r) begin
        tick(1'b1, en, wr);
      end else begin
        tick(1'b0, en, wr);
      end
      total++; if (bus.empty !== m_empty) begin bad++; $display("FAIL rnd_empty@%0d: got %b need %b", n, bus.empty, m_empty); end
      total++; if (bus.r_level !== 4'(m_level)) begin bad++; $display("FAIL rnd_level@%0d: got %0d need %0d", n, bus.r_level, m_level); end
      total++; if (bus.almost_empty !== m_ae) begin bad++; $display("FAIL rnd_ae@%0d: got %b need %b", n, bus.almost_empty, m_ae); end
      total++; if (bus.underflow !== m_uf) begin bad++; $display("FAIL rnd_underflow@%0d: got %b need %b", n, bus.underflow, m_uf); end
      total++; if (bus.rptr !== exp_rptr()) begin bad++; $display("FAIL rnd_rptr@%0d: got %b need %b", n, bus.rptr, exp_rptr()); end
      total++; if (bus.raddr !== exp_raddr()) begin bad++; $display("FAIL rnd_raddr@%0d: got %0d need %0d", n, bus.raddr, exp_raddr()); end
      if (!r && m_rd != rd_before) begin
        total++; if ($countones(prev ^ bus.rptr) != 1) begin bad++; $display("FAIL rnd_gray_step@%0d: %b -> %b", n, prev, bus.rptr); end
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.r_en       = 1'b0;
    bus.rsync_ptr2 = 4'b0000;
    m_wr = 0; m_rd = 0; m_level = 0;
    m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0;
    test_reset();
    test_first_data();
    test_drain();
    test_full_wrap();
    test_underflow();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
